rr_stream_mux: RTL and testbench

//  Parametrised N-channel, W-bit stream multiplexer with a registered output stage.
//  Two modes: fixed-address select, or round-robin arbitration among requesting channels.

---
 rtl/rr_stream_mux.sv | 213 +++++++++++++++++++++
 tb/tb_rr_stream_mux.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream multiplexer with a registered
// output stage. mode=0 selects the channel given by address; mode=1 arbitrates
// round-robin among requesting channels.
// Optional feature macro: PACKET_LOCK_EN. It adds in_last/out_last and an
// IDLE/LOCKED FSM that keeps the grant on one channel until the final beat of a packet.
module rr_stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          address,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
`ifdef PACKET_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_channel
);

  // Output stage and round-robin pointer
  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_valid;
  logic [SEL_W-1:0]    r_out_channel;
  logic [SEL_W-1:0]    r_ptr;

  // Arbitration wires
  logic [CHANNELS-1:0] w_rot;
  int                  w_rr_off;
  int                  w_rr_idx;
  logic [SEL_W-1:0]    w_rr_grant;
  logic [SEL_W-1:0]    w_grant;
  logic                w_grant_ok;
  logic                w_open;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_sel_last;
  logic [CHANNELS-1:0] w_last_in;
  logic                w_locked;
  logic [SEL_W-1:0]    w_lock_ch;
  logic                w_ptr_adv;
  logic [SEL_W-1:0]    w_ptr_nxt;

`ifdef PACKET_LOCK_EN
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_lock_ch;
  logic [SEL_W-1:0] w_lock_ch_nxt;
  logic             r_out_last;

  assign w_last_in = in_last;
  assign w_locked  = (r_state == S_LOCKED);
  assign w_lock_ch = r_lock_ch;
  assign out_last  = r_out_last;
`else
  // Without packet locking every beat is a complete packet of its own.
  assign w_last_in = {CHANNELS{1'b1}};
  assign w_locked  = 1'b0;
  assign w_lock_ch = {SEL_W{1'b0}};
`endif

  assign w_open = !r_out_valid || out_ready;
  assign w_xfer = w_open && w_grant_ok;

  // Round-robin search: rotate the request vector so bit 0 is the pointer
  // channel, take the lowest set bit, then map the offset back to a channel.
  always_comb begin
    w_rot    = CHANNELS'({in_valid, in_valid} >> r_ptr);
    w_rr_off = 0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_rr_off = w_rot[i] ? i : w_rr_off;
    end
    w_rr_idx = int'(r_ptr) + w_rr_off;
    if (w_rr_idx >= CHANNELS) begin
      w_rr_idx = w_rr_idx - CHANNELS;
    end else begin
      w_rr_idx = w_rr_idx;
    end
    w_rr_grant = SEL_W'(w_rr_idx);
  end

  // Grant source: a locked packet overrides both modes.
  always_comb begin
    w_grant = address;
    if (w_locked) begin
      w_grant = w_lock_ch;
    end else if (mode) begin
      w_grant = w_rr_grant;
    end else begin
      w_grant = address;
    end
  end

  // Per-channel view of the granted channel. An out-of-range address matches
  // no channel, so grant_ok stays low and nothing is accepted.
  always_comb begin
    w_grant_ok = 1'b0;
    w_sel_data = {WIDTH{1'b0}};
    w_sel_last = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_grant_ok = (w_grant == SEL_W'(k)) ? in_valid[k] : w_grant_ok;
      w_sel_data = (w_grant == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : w_sel_data;
      w_sel_last = (w_grant == SEL_W'(k)) ? w_last_in[k] : w_sel_last;
    end
  end

  // One-hot (or zero) accept toward the producers.
  always_comb begin
    in_ready = {CHANNELS{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      in_ready[k] = w_xfer && (w_grant == SEL_W'(k));
    end
  end

  // Pointer moves past the served channel only when a packet completes in rr mode.
  assign w_ptr_adv = w_xfer && mode && w_sel_last;
  assign w_ptr_nxt = (w_grant == SEL_W'(CHANNELS - 1)) ? {SEL_W{1'b0}} : (w_grant + SEL_W'(1));

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= {SEL_W{1'b0}};
    end else if (w_ptr_adv) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Output stage: load on accept (replacing any beat taken this cycle), drain otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= {WIDTH{1'b0}};
      r_out_channel <= {SEL_W{1'b0}};
    end else if (w_xfer) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= w_sel_data;
      r_out_channel <= w_grant;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end else begin
      r_out_valid   <= r_out_valid;
    end
  end

`ifdef PACKET_LOCK_EN
  // Last flag travels with the data beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_out_last <= w_sel_last;
    end else begin
      r_out_last <= r_out_last;
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lock_ch <= {SEL_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_ch_nxt;
    end
  end

  // Packet FSM next state: lock on a non-final beat, release on the final one.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_ch_nxt = r_lock_ch;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && !w_sel_last) begin
          w_state_nxt   = S_LOCKED;
          w_lock_ch_nxt = w_grant;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (w_xfer && w_sel_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LOCKED;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end
`endif

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_channel = r_out_channel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux with a per-cycle reference model.
// The address port is one bit wider than needed so an out-of-range address
// (5 with 4 channels) can be driven.
module tb_rr_stream_mux;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 3;

  logic                      clk;
  logic                      reset;
  logic                      mode;
  logic [SEL_W-1:0]          address;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          out_channel;
`ifdef PACKET_LOCK_EN
  logic [CHANNELS-1:0]       in_last;
  logic                      out_last;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rr_stream_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .address     (address),
    .in_data     (in_data),
    .in_valid    (in_valid),
`ifdef PACKET_LOCK_EN
    .in_last     (in_last),
    .out_last    (out_last),
`endif
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_chan;
  int               m_ptr;
  logic             m_locked;
  int               m_lock;
  logic             m_last;
  int               g;
  int               k;
  logic             ok;
  logic             open_s;
  logic [CHANNELS-1:0] exp_rdy;
  logic             beat_last;

  // Compare DUT against the model, then advance the model by one clock.
  always @(negedge clk) begin
    if (reset) begin
      m_valid  = 1'b0;
      m_data   = '0;
      m_chan   = 0;
      m_ptr    = 0;
      m_locked = 1'b0;
      m_lock   = 0;
      m_last   = 1'b0;
    end else begin
      chk("mdl_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("mdl_out_data", out_data, m_data);
        chk("mdl_out_channel", out_channel, m_chan);
`ifdef PACKET_LOCK_EN
        chk("mdl_out_last", out_last, m_last);
`endif
      end
      ok = 1'b0;
      g  = 0;
      if (m_locked) begin
        g  = m_lock;
        ok = in_valid[g];
      end else if (!mode) begin
        if (int'(address) < CHANNELS) begin
          g  = int'(address);
          ok = in_valid[g];
        end
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          k = (m_ptr + i) % CHANNELS;
          if (!ok && in_valid[k]) begin
            ok = 1'b1;
            g  = k;
          end
        end
      end
      open_s  = !m_valid || out_ready;
      exp_rdy = (open_s && ok) ? (4'b0001 << g) : 4'b0000;
      chk("mdl_in_ready", in_ready, exp_rdy);
      if (open_s && ok) begin
        m_valid = 1'b1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_chan  = g;
`ifdef PACKET_LOCK_EN
        beat_last = in_last[g];
`else
        beat_last = 1'b1;
`endif
        m_last = beat_last;
        if (beat_last) begin
          m_locked = 1'b0;
          if (mode) m_ptr = (g + 1) % CHANNELS;
        end else begin
          m_locked = 1'b1;
          m_lock   = g;
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int rr_all [6] = '{0, 1, 2, 3, 0, 1};
  int rr_odd [4] = '{1, 3, 1, 3};

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    address   = '0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
`ifdef PACKET_LOCK_EN
    in_last   = '0;
`endif
    tick();
    tick();
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_channel", out_channel, 0);
    reset = 1'b0;

    // Fixed select
    mode      = 1'b0;
    address   = 3'd2;
    in_valid  = 4'b0100;
    in_data[2*WIDTH +: WIDTH] = 8'hA5;
    out_ready = 1'b1;
    #1;
    chk("fix_in_ready", in_ready, 4'b0100);
    tick();
    chk("fix_valid", out_valid, 1);
    chk("fix_data", out_data, 8'hA5);
    chk("fix_channel", out_channel, 2);
    address  = 3'd5;
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    #1;
    chk("fix_oob_ready", in_ready, 4'b0000);
    tick();
    chk("fix_oob_idle", out_valid, 0);

    // Round robin, all channels requesting
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_all_channel", out_channel, rr_all[i]);
      chk("rr_all_data", out_data, 32'h10 + rr_all[i]);
    end

    // Asynchronous reset with a beat held in the output stage
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_channel", out_channel, 0);
    in_valid = 4'b1010;
    tick();
    reset = 1'b0;

    // Round robin, channels 1 and 3 only, pointer back at 0
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_odd_channel", out_channel, rr_odd[i]);
    end

    // Backpressure: ch3 beat (8'h13) must hold
    out_ready = 1'b0;
    in_valid  = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'h13);
      chk("bp_channel", out_channel, 3);
      chk("bp_in_ready", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 4'b0001);
    tick();
    chk("nobubble_valid", out_valid, 1);
    chk("nobubble_channel", out_channel, 0);
    chk("nobubble_data", out_data, 8'h10);
    tick();
    chk("nobubble2_channel", out_channel, 1);
    in_valid = 4'b1000;
    tick();
    chk("nobubble3_channel", out_channel, 3);
    in_valid = 4'b0000;
    tick();
    chk("drain_valid", out_valid, 0);

`ifdef PACKET_LOCK_EN
    // One-beat packet from ch0 moves the pointer to 1
    in_last  = 4'b1111;
    in_valid = 4'b0001;
    tick();
    chk("lk_single_channel", out_channel, 0);
    chk("lk_single_last", out_last, 1);
    // ch1 three-beat packet while ch0/ch2 request
    in_valid = 4'b0111;
    in_last  = 4'b1101;
    tick();
    chk("lk_b1_channel", out_channel, 1);
    chk("lk_b1_last", out_last, 0);
    tick();
    chk("lk_b2_channel", out_channel, 1);
    in_last = 4'b1111;
    tick();
    chk("lk_b3_channel", out_channel, 1);
    chk("lk_b3_last", out_last, 1);
    tick();
    chk("lk_after_channel", out_channel, 2);
    // Lock ch1 again, reset after beat 2
    in_valid = 4'b0010;
    in_last  = 4'b1101;
    tick();
    chk("lk2_b1_channel", out_channel, 1);
    in_valid = 4'b0111;
    tick();
    chk("lk2_b2_channel", out_channel, 1);
    reset = 1'b1;
    #1;
    chk("lk_rst_valid", out_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("lk_rst_next_channel", out_channel, 0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
